fetch_ctrl: RTL and testbench

Instruction-fetch controller for the P7 MIPS pipeline. It owns the program counter and sequences every access to the instruction memory: issue, wait-state handling, stall, branch and exception/`eret` redirection, and fetch address-error (AdEL) detection. It presents the F-stage result (`f_pc`, `f_instr`, exception tag) to the F/D boundary. The instruction memory may be single-cycle (`imem_ready` tied high) or multi-cycle.

---
 rtl/fetch_ctrl_if.sv | 28 ++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Instruction-memory request/response bundle between the fetch
//            controller (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : P7 instruction-fetch controller. Owns the PC, sequences imem
//            accesses (wait states, stall, delayed branch, exception / eret
//            redirection) and tags misaligned / out-of-text fetches as AdEL.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_END  = 32'h0000_6FFC,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        stall,
  input  wire logic        req_exc,
  input  wire logic        req_eret,
  input  wire logic [31:0] epc,
  input  wire logic        req_br,
  input  wire logic [31:0] br_target,
  fetch_ctrl_if.master     imem,
  output logic [31:0]      f_pc,
  output logic [31:0]      f_instr,
  output logic             f_valid,
  output logic             f_exc,
  output logic [4:0]       f_exccode
);

  localparam logic [4:0] C_EXC_ADEL = 5'd4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        br_pend_q;
  logic [31:0] br_tgt_q;
  logic [31:0] f_pc_q;
  logic [31:0] f_instr_q;
  logic        f_valid_q;
  logic        f_exc_q;
  logic [4:0]  f_exccode_q;

  logic        w_bad;
  logic        w_cap;
  logic        w_done;
  logic        w_br_take;
  logic [31:0] w_pc_seq;

  // Decode fetch legality, capture window and completion for the current PC.
  always_comb begin
    w_bad     = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_BASE) || (pc_q > TEXT_END);
    // A held F/D slot (stall with valid data) blocks capture; redirects pre-empt it.
    w_cap     = (state_q == FETCH) && (!stall || !f_valid_q) && !req_exc && !req_eret;
    // A bad address completes at once without touching memory.
    w_done    = w_cap && (w_bad || imem.imem_ready);
    w_br_take = req_br && !stall;
    // Successor PC when a fetch completes without a same-cycle branch.
    w_pc_seq  = br_pend_q ? br_tgt_q : (pc_q + 32'd4);
  end

  // PC, state machine and registered F-stage result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= 32'd0;
      f_pc_q      <= 32'd0;
      f_instr_q   <= 32'd0;
      f_valid_q   <= 1'b0;
      f_exc_q     <= 1'b0;
      f_exccode_q <= 5'd0;
    end else if (req_exc || req_eret) begin
      // Redirect wins over everything; any in-flight fetch is abandoned.
      state_q   <= FETCH;
      pc_q      <= req_exc ? EXC_ENTRY : epc;
      f_valid_q <= 1'b0;
      f_exc_q   <= 1'b0;
      br_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
        end
        FETCH: begin
          if (w_done) begin
            f_pc_q      <= pc_q;
            f_instr_q   <= w_bad ? 32'd0 : imem.imem_rdata;
            f_valid_q   <= 1'b1;
            f_exc_q     <= w_bad;
            f_exccode_q <= w_bad ? C_EXC_ADEL : 5'd0;
            // The word just completed is the delay slot of a same-cycle branch.
            if (w_br_take) begin
              pc_q <= br_target;
            end else begin
              pc_q <= w_pc_seq;
            end
            br_pend_q <= 1'b0;
          end else if (w_br_take) begin
            // Branch arrived before its delay slot completed: remember it.
            br_pend_q <= 1'b1;
            br_tgt_q  <= br_target;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req  = w_cap && !w_bad && !reset;
  assign imem.imem_addr = pc_q;
  assign f_pc           = f_pc_q;
  assign f_instr        = f_instr_q;
  assign f_valid        = f_valid_q;
  assign f_exc          = f_exc_q;
  assign f_exccode      = f_exccode_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl. The memory returns
//            address ^ 32'hDEAD_0000 so every fetched word is predictable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] C_MEM_KEY = 32'hDEAD_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req_exc;
  logic        req_eret;
  logic [31:0] epc;
  logic        req_br;
  logic [31:0] br_target;
  logic        ready;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_exc;
  logic [4:0]  f_exccode;

  int n_vec;
  int n_err;

  fetch_ctrl_if mem_if ();

  assign mem_if.imem_ready = ready;
  assign mem_if.imem_rdata = mem_if.imem_addr ^ C_MEM_KEY;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req_exc   (req_exc),
    .req_eret  (req_eret),
    .epc       (epc),
    .req_br    (req_br),
    .br_target (br_target),
    .imem      (mem_if.master),
    .f_pc      (f_pc),
    .f_instr   (f_instr),
    .f_valid   (f_valid),
    .f_exc     (f_exc),
    .f_exccode (f_exccode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; req_exc = 1'b0; req_eret = 1'b0; epc = 32'd0;
    req_br = 1'b0; br_target = 32'd0; ready = 1'b1;
    step(); step();
    n_vec++; if ({f_pc, f_instr} !== 64'd0) begin n_err++; $display("FAIL reset_f got %h/%h exp 0/0", f_pc, f_instr); end
    n_vec++; if ({f_valid, f_exc, f_exccode, mem_if.imem_req} !== 8'd0) begin n_err++; $display("FAIL reset_flags got %b%b%h%b exp 0", f_valid, f_exc, f_exccode, mem_if.imem_req); end
    reset = 1'b0;
    #1;
    n_vec++; if (mem_if.imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req got %b exp 0", mem_if.imem_req); end
    step();
    n_vec++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 32'h3000) begin n_err++; $display("FAIL first_req got %b/%h exp 1/00003000", mem_if.imem_req, mem_if.imem_addr); end
    n_vec++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL first_valid got %b exp 0", f_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 32'h3000 + 32'(4 * i);
      n_vec++; if (f_pc !== exp_pc || f_valid !== 1'b1) begin n_err++; $display("FAIL seq_pc got %h/%b exp %h/1", f_pc, f_valid, exp_pc); end
      n_vec++; if (f_instr !== (exp_pc ^ C_MEM_KEY) || f_exc !== 1'b0) begin n_err++; $display("FAIL seq_instr got %h/%b exp %h/0", f_instr, f_exc, exp_pc ^ C_MEM_KEY); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (mem_if.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req got %b exp 0", mem_if.imem_req); end
      step();
      n_vec++; if (f_pc !== 32'h3008 || f_instr !== (32'h3008 ^ C_MEM_KEY)) begin n_err++; $display("FAIL stall_hold got %h/%h exp 00003008/%h", f_pc, f_instr, 32'h3008 ^ C_MEM_KEY); end
    end
    stall = 1'b0;
    step();
    n_vec++; if (f_pc !== 32'h300C) begin n_err++; $display("FAIL stall_release got %h exp 0000300c", f_pc); end
  endtask

  task automatic test_branch_wait();
    ready = 1'b0; req_br = 1'b1; br_target = 32'h3100;
    #1;
    n_vec++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 32'h3010) begin n_err++; $display("FAIL wait_req got %b/%h exp 1/00003010", mem_if.imem_req, mem_if.imem_addr); end
    step();
    req_br = 1'b0;
    n_vec++; if (f_pc !== 32'h300C || mem_if.imem_addr !== 32'h3010) begin n_err++; $display("FAIL wait_hold got %h/%h exp 0000300c/00003010", f_pc, mem_if.imem_addr); end
    step();
    n_vec++; if (f_pc !== 32'h300C) begin n_err++; $display("FAIL wait_hold2 got %h exp 0000300c", f_pc); end
    ready = 1'b1;
    step();
    n_vec++; if (f_pc !== 32'h3010 || mem_if.imem_addr !== 32'h3100) begin n_err++; $display("FAIL delay_slot got %h/%h exp 00003010/00003100", f_pc, mem_if.imem_addr); end
    step();
    n_vec++; if (f_pc !== 32'h3100 || f_instr !== (32'h3100 ^ C_MEM_KEY)) begin n_err++; $display("FAIL br_target got %h/%h exp 00003100", f_pc, f_instr); end
    step();
    n_vec++; if (f_pc !== 32'h3104) begin n_err++; $display("FAIL br_after got %h exp 00003104", f_pc); end
  endtask

  task automatic test_redirect();
    req_exc = 1'b1; req_eret = 1'b1; epc = 32'h3200; req_br = 1'b1; br_target = 32'h3300;
    #1;
    n_vec++; if (mem_if.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req got %b exp 0", mem_if.imem_req); end
    step();
    req_exc = 1'b0; req_eret = 1'b0; req_br = 1'b0;
    n_vec++; if (mem_if.imem_addr !== 32'h4180 || f_valid !== 1'b0) begin n_err++; $display("FAIL redir got %h/%b exp 00004180/0", mem_if.imem_addr, f_valid); end
    step();
    n_vec++; if (f_pc !== 32'h4180 || f_valid !== 1'b1) begin n_err++; $display("FAIL handler got %h/%b exp 00004180/1", f_pc, f_valid); end
    // eret alone beats a branch.
    req_eret = 1'b1; epc = 32'h3200; req_br = 1'b1; br_target = 32'h3300;
    step();
    req_eret = 1'b0; req_br = 1'b0;
    n_vec++; if (mem_if.imem_addr !== 32'h3200 || f_valid !== 1'b0) begin n_err++; $display("FAIL eret got %h/%b exp 00003200/0", mem_if.imem_addr, f_valid); end
    step();
    n_vec++; if (f_pc !== 32'h3200) begin n_err++; $display("FAIL eret_fetch got %h exp 00003200", f_pc); end
  endtask

  task automatic test_adel();
    logic [31:0] bad_pcs [2];
    bad_pcs[0] = 32'h3002;
    bad_pcs[1] = 32'h7000;
    for (int i = 0; i < 2; i++) begin
      req_eret = 1'b1; epc = bad_pcs[i];
      step();
      req_eret = 1'b0;
      #1;
      n_vec++; if (mem_if.imem_req !== 1'b0) begin n_err++; $display("FAIL adel_req got %b exp 0", mem_if.imem_req); end
      step();
      n_vec++; if (f_pc !== bad_pcs[i] || f_instr !== 32'd0 || f_valid !== 1'b1) begin n_err++; $display("FAIL adel_f got %h/%h/%b exp %h/0/1", f_pc, f_instr, f_valid, bad_pcs[i]); end
      n_vec++; if (f_exc !== 1'b1 || f_exccode !== 5'd4) begin n_err++; $display("FAIL adel_code got %b/%0d exp 1/4", f_exc, f_exccode); end
    end
    req_eret = 1'b1; epc = 32'h3000;
    step();
    req_eret = 1'b0;
    step();
    n_vec++; if (f_pc !== 32'h3000 || f_exc !== 1'b0 || f_exccode !== 5'd0) begin n_err++; $display("FAIL adel_clear got %h/%b/%0d exp 00003000/0/0", f_pc, f_exc, f_exccode); end
  endtask

  task automatic test_reset_mid_wait();
    ready = 1'b0; req_br = 1'b1; br_target = 32'h3400;
    step();
    req_br = 1'b0; reset = 1'b1;
    step();
    n_vec++; if ({f_pc, f_instr} !== 64'd0 || f_valid !== 1'b0 || mem_if.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_wait got %h/%h/%b/%b exp 0", f_pc, f_instr, f_valid, mem_if.imem_req); end
    n_vec++; if (mem_if.imem_addr !== 32'h3000) begin n_err++; $display("FAIL rst_pc got %h exp 00003000", mem_if.imem_addr); end
    reset = 1'b0; ready = 1'b1;
    step();
    n_vec++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 32'h3000) begin n_err++; $display("FAIL rst_req got %b/%h exp 1/00003000", mem_if.imem_req, mem_if.imem_addr); end
    step();
    n_vec++; if (f_pc !== 32'h3000 || f_valid !== 1'b1) begin n_err++; $display("FAIL rst_first got %h/%b exp 00003000/1", f_pc, f_valid); end
    step();
    n_vec++; if (f_pc !== 32'h3004) begin n_err++; $display("FAIL rst_nopend got %h exp 00003004", f_pc); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_redirect();
    test_adel();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
